// File: rtl/fft_pkg.sv
// fft_pkg: types and constants shared by the FFT front end and the FFT pipeline.
//   FFT_N     : points per transform (power of two)
//   FFT_DW    : sample width, signed two's complement
//   sample_t  : one signed sample
//   cplx_t    : complex sample {re, im}
//   idx_w()   : width of an index into an n-entry array (at least 1 bit)
package fft_pkg;

    localparam int FFT_N  = 8;
    localparam int FFT_DW = 16;

    typedef logic signed [FFT_DW-1:0] sample_t;

    typedef struct packed {
        sample_t re;
        sample_t im;
    } cplx_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: N-entry complex register bank, one write port, full parallel read.
//   clk, rst        : clock, asynchronous active-low reset (clears every entry)
//   wr_en           : write wr_re/wr_im into entry wr_idx on the rising edge
//   wr_idx          : target entry
//   wr_re, wr_im    : sample to store
//   rd_re, rd_im    : all N entries, entry i on element i
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int N  = FFT_N,
    parameter int DW = FFT_DW,
    localparam int IW = idx_w(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_idx,
    input  logic signed [DW-1:0] wr_re,
    input  logic signed [DW-1:0] wr_im,
    output logic signed [DW-1:0] rd_re [0:N-1],
    output logic signed [DW-1:0] rd_im [0:N-1]
);

    for (genvar e = 0; e < N; e++) begin : g_entry
        logic hit;
        assign hit = wr_en && (wr_idx == IW'(e));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_re[e] <= '0;
                rd_im[e] <= '0;
            end else if (hit) begin
                rd_re[e] <= wr_re;
                rd_im[e] <= wr_im;
            end
        end
    end

endmodule

// File: rtl/fft_input_framer.sv
// fft_input_framer: packs a serial complex sample stream into N-sample frames
// using a ping-pong pair of banks and presents each full frame in parallel.
//   clk, rst            : clock, asynchronous active-low reset
//   in_valid/in_ready   : sample handshake; in_ready depends on registers only
//   in_r, in_i, in_last : sample and end-of-frame marker (expected on index N-1)
//   out_valid/out_ready : frame handshake
//   out_r, out_i        : frame samples, index i on element i
//   frame_cnt           : frames handed downstream, wraps
//   err_sync, clr_err   : sticky framing-error flag and its synchronous clear
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int N  = FFT_N,
    parameter int DW = FFT_DW,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_r,
    input  logic signed [DW-1:0] in_i,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_r [0:N-1],
    output logic signed [DW-1:0] out_i [0:N-1],
    output logic [CW-1:0]        frame_cnt,
    output logic                 err_sync,
    input  logic                 clr_err
);

    localparam int IW = idx_w(N);

    logic [1:0]    full;
    logic          wr_sel;
    logic          rd_sel;
    logic [IW-1:0] wr_idx;

    logic accept, at_end, complete, early_last, err_evt, handoff;
    logic [1:0] bank_we;

    logic signed [DW-1:0] b_re [0:1][0:N-1];
    logic signed [DW-1:0] b_im [0:1][0:N-1];

    assign in_ready   = !full[wr_sel];
    assign accept     = in_valid && in_ready;
    assign at_end     = (wr_idx == IW'(N-1));
    assign complete   = accept && at_end;
    assign early_last = accept && in_last && !at_end;
    // Length decides the frame boundary; a missing last is flagged but the
    // frame still goes out.
    assign err_evt    = early_last || (complete && !in_last);

    assign out_valid  = full[rd_sel];
    assign handoff    = out_valid && out_ready;

    assign bank_we    = {accept && wr_sel, accept && !wr_sel};

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_frame_bank #(.N(N), .DW(DW)) u_bank (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (bank_we[g]),
            .wr_idx (wr_idx),
            .wr_re  (in_r),
            .wr_im  (in_i),
            .rd_re  (b_re[g]),
            .rd_im  (b_im[g])
        );
    end

    for (genvar i = 0; i < N; i++) begin : g_out
        assign out_r[i] = rd_sel ? b_re[1][i] : b_re[0][i];
        assign out_i[i] = rd_sel ? b_im[1][i] : b_im[0][i];
    end

    // A completing bank and a handed-off bank are always different banks:
    // a bank being read out is full, so it cannot also be the write target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full      <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_idx    <= '0;
            frame_cnt <= '0;
            err_sync  <= 1'b0;
        end else begin
            if (complete) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= !wr_sel;
            end
            if (handoff) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= !rd_sel;
                frame_cnt    <= frame_cnt + CW'(1);
            end
            // Early last drops the partial frame: just rewind the index.
            if (accept)
                wr_idx <= (at_end || in_last) ? '0 : wr_idx + IW'(1);
            if (err_evt)
                err_sync <= 1'b1;
            else if (clr_err)
                err_sync <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_input_framer.sv
// Bench for fft_input_framer: directed scenarios plus random traffic, checked
// every cycle against a queue-of-frames model.
module tb_fft_input_framer;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int CW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_r = '0;
    logic signed [DW-1:0] in_i = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] out_r [0:N-1];
    logic signed [DW-1:0] out_i [0:N-1];
    logic [CW-1:0]        frame_cnt;
    logic                 err_sync;
    logic                 clr_err = 1'b0;

    fft_input_framer #(.N(N), .DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_i      (in_i),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .frame_cnt (frame_cnt),
        .err_sync  (err_sync),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0][DW-1:0] re;
        logic [N-1:0][DW-1:0] im;
    } fr_t;

    // Model: completed frames waiting downstream, plus the frame being filled.
    fr_t           m_q[$];
    fr_t           m_part;
    int            m_pcnt;
    logic [CW-1:0] m_cnt;
    logic          m_err;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic fr_t dut_frame();
        fr_t f;
        for (int j = 0; j < N; j++) begin
            f.re[j] = out_r[j];
            f.im[j] = out_i[j];
        end
        return f;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_part = '0;
        m_pcnt = 0;
        m_cnt  = '0;
        m_err  = 1'b0;
    endtask

    // Compare DUT against the model, advance the model by one edge, step clock.
    task automatic cycle();
        fr_t f;
        logic acc, hand, evt;
        chk("in_ready",  128'(in_ready),  128'(m_q.size() < 2));
        chk("out_valid", 128'(out_valid), 128'(m_q.size() > 0));
        chk("frame_cnt", 128'(frame_cnt), 128'(m_cnt));
        chk("err_sync",  128'(err_sync),  128'(m_err));
        if (m_q.size() > 0) begin
            f = dut_frame();
            chk("frame_re", 128'(f.re), 128'(m_q[0].re));
            chk("frame_im", 128'(f.im), 128'(m_q[0].im));
        end
        acc  = in_valid && (m_q.size() < 2);
        hand = out_ready && (m_q.size() > 0);
        evt  = 1'b0;
        if (hand) begin
            void'(m_q.pop_front());
            m_cnt = m_cnt + 1'b1;
        end
        if (acc) begin
            m_part.re[m_pcnt] = in_r;
            m_part.im[m_pcnt] = in_i;
            m_pcnt++;
            if (m_pcnt == N) begin
                m_q.push_back(m_part);
                if (!in_last) evt = 1'b1;
                m_pcnt = 0;
            end else if (in_last) begin
                evt = 1'b1;
                m_pcnt = 0;
            end
        end
        if (evt) m_err = 1'b1;
        else if (clr_err) m_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Offer one sample and keep it offered until accepted (bounded).
    task automatic send(input int re, input int im, input logic last);
        int tries = 0;
        in_valid = 1'b1;
        in_r     = re[DW-1:0];
        in_i     = im[DW-1:0];
        in_last  = last;
        while (!(m_q.size() < 2)) begin
            if (tries++ > 100) begin
                n_vec++;
                n_bad++;
                $display("FAIL send_timeout: sample %0d never accepted", re);
                break;
            end
            cycle();
        end
        cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    fr_t exp_f;

    initial begin
        model_reset();
        #12;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready",  128'(in_ready),  128'(1));
        chk("rst_out_r",     128'(dut_frame()), 128'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: one clean frame re=k, im=-k
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) send(k, -k, k == N-1);
        for (int k = 0; k < N; k++) begin
            exp_f.re[k] = DW'(k);
            exp_f.im[k] = DW'(-k);
        end
        chk("t1_valid", 128'(out_valid), 128'(1));
        chk("t1_frame", 128'(dut_frame()), 128'(exp_f));
        chk("t1_cnt0",  128'(frame_cnt), 128'(0));
        idle(1);
        chk("t1_cnt1",  128'(frame_cnt), 128'(1));
        chk("t1_valid_low", 128'(out_valid), 128'(0));
        chk("t1_err",   128'(err_sync), 128'(0));

        // 2: 32 back-to-back samples
        for (int k = 0; k < 32; k++) send(1000 + k, 2000 - k, (k % N) == N-1);
        idle(1);
        chk("t2_cnt", 128'(frame_cnt), 128'(5));

        // 3: backpressure, both banks fill
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) send(200 + k, k, (k % N) == N-1);
        chk("t3_ready_low", 128'(in_ready), 128'(0));
        chk("t3_valid",     128'(out_valid), 128'(1));
        in_valid = 1'b1;
        in_r     = 16'sd216;
        idle(3);
        in_valid = 1'b0;
        chk("t3_stable_r0", 128'(out_r[0]), 128'(200));
        out_ready = 1'b1;
        for (int k = 16; k < 20; k++) send(200 + k, k, 1'b0);
        idle(3);
        chk("t3_ready_back", 128'(in_ready), 128'(1));
        chk("t3_cnt", 128'(frame_cnt), 128'(7));
        for (int k = 20; k < 24; k++) send(200 + k, k, k == 23);
        idle(2);

        // 4: early last on index 4, then clean frame 100..107
        for (int k = 0; k < 5; k++) send(50 + k, 0, k == 4);
        chk("t4_err", 128'(err_sync), 128'(1));
        chk("t4_no_out", 128'(out_valid), 128'(0));
        for (int k = 0; k < N; k++) send(100 + k, 7, k == N-1);
        for (int k = 0; k < N; k++) begin
            exp_f.re[k] = DW'(100 + k);
            exp_f.im[k] = DW'(7);
        end
        chk("t4_valid", 128'(out_valid), 128'(1));
        chk("t4_frame", 128'(dut_frame()), 128'(exp_f));
        idle(1);

        // 5: missing last, clear, clear racing an error
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("t5_cleared", 128'(err_sync), 128'(0));
        for (int k = 0; k < N; k++) send(400 + k, 1, 1'b0);
        chk("t5_delivered", 128'(out_valid), 128'(1));
        chk("t5_err", 128'(err_sync), 128'(1));
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("t5_clr", 128'(err_sync), 128'(0));
        clr_err = 1'b1;
        for (int k = 0; k < 3; k++) send(500 + k, 0, k == 2);
        clr_err = 1'b0;
        chk("t5_err_wins", 128'(err_sync), 128'(1));
        idle(1);

        // 6: async reset mid-frame with a full frame pending
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) send(600 + k, 3, k == N-1);
        for (int k = 0; k < 3; k++) send(700 + k, 3, 1'b0);
        chk("t6_pending", 128'(out_valid), 128'(1));
        rst = 1'b0;
        #1;
        chk("t6_valid0", 128'(out_valid), 128'(0));
        chk("t6_data0",  128'(dut_frame()), 128'(0));
        chk("t6_ready",  128'(in_ready), 128'(1));
        chk("t6_cnt0",   128'(frame_cnt), 128'(0));
        chk("t6_err0",   128'(err_sync), 128'(0));
        model_reset();
        #2;
        rst = 1'b1;
        out_ready = 1'b1;
        idle(1);
        for (int k = 0; k < N; k++) send(300 + k, -k, k == N-1);
        for (int k = 0; k < N; k++) begin
            exp_f.re[k] = DW'(300 + k);
            exp_f.im[k] = DW'(-k);
        end
        chk("t6_frame", 128'(dut_frame()), 128'(exp_f));
        idle(1);
        chk("t6_cnt1", 128'(frame_cnt), 128'(1));

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom % 2) == 0;
            in_valid  = ($urandom % 4) != 0;
            in_r      = DW'($urandom);
            in_i      = DW'($urandom);
            in_last   = (m_pcnt == N-1) ^ (($urandom % 20) == 0);
            clr_err   = ($urandom % 16) == 0;
            cycle();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        clr_err  = 1'b0;
        out_ready = 1'b1;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
